// File: rtl/mux_scan_pkg.sv
// Shared types for the mux select sequencer.
// Includes the FSM state encoding and the channel-count constants.
package mux_scan_pkg;

  localparam int NCH   = 4;
  localparam int SEL_W = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

endpackage

// File: rtl/mux_scan_next.sv
// Channel picker for the round-robin scan.
// Gives the next enabled channel after cur, and the lowest enabled channel.
module mux_scan_next
  import mux_scan_pkg::*;
(
  input  logic [SEL_W-1:0] cur,
  input  logic [NCH-1:0]   en_mask,
  output logic [SEL_W-1:0] nxt,
  output logic             any,
  output logic [SEL_W-1:0] first
);

  logic [SEL_W-1:0] w_idx;

  // Walk downwards so the nearest enabled channel after cur wins.
  always_comb begin
    w_idx = '0;
    nxt   = cur;
    for (int k = NCH - 1; k >= 1; k--) begin
      w_idx = cur + SEL_W'(k);
      if (en_mask[w_idx]) nxt = w_idx;
    end
  end

  always_comb begin
    first = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (en_mask[i]) first = SEL_W'(i);
    end
  end

  assign any = |en_mask;

endmodule

// File: rtl/mux_scan_ctrl.sv
// Select sequencer for the registered 4:1 channel mux.
// The sample strobe trails the select by one cycle so it lines up with the mux output.
module mux_scan_ctrl
  import mux_scan_pkg::*;
#(
  parameter int DWELL_W = 4,
  parameter int CNT_W   = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stop,
  input  logic [NCH-1:0]     en_mask,
  input  logic [DWELL_W-1:0] dwell,
  output logic [SEL_W-1:0]   s,
  output logic               busy,
  output logic               smp_valid,
  output logic [SEL_W-1:0]   smp_ch,
  output logic [CNT_W-1:0]   visit_cnt
);

  state_e             r_state;
  state_e             w_state_nxt;
  logic               r_busy;
  logic [SEL_W-1:0]   r_s;
  logic [DWELL_W-1:0] r_dcnt;
  logic               r_stop_pend;
  logic [SEL_W-1:0]   r_tag;
  logic               r_valid;
  logic [CNT_W-1:0]   r_cnt;

  logic [SEL_W-1:0]   w_nxt;
  logic [SEL_W-1:0]   w_first;
  logic               w_any;
  logic               w_enter;
  logic               w_done;
  logic               w_halt;

  mux_scan_next u_next (
    .cur     (r_s),
    .en_mask (en_mask),
    .nxt     (w_nxt),
    .any     (w_any),
    .first   (w_first)
  );

  assign w_enter = (r_state == ST_IDLE) && start && !stop && w_any;
  assign w_done  = (r_state == ST_SCAN) && (r_dcnt == '0);
  assign w_halt  = r_stop_pend || stop || !w_any;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt != ST_IDLE);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (1'b1)
      (r_state == ST_IDLE):  if (w_enter) w_state_nxt = ST_SCAN;
      (r_state == ST_SCAN):  if (w_done && w_halt) w_state_nxt = ST_DRAIN;
      (r_state == ST_DRAIN): w_state_nxt = ST_IDLE;
      default:               w_state_nxt = ST_IDLE;
    endcase
  end

  // The select holds through DRAIN so the mux keeps the last channel.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s         <= '0;
      r_dcnt      <= '0;
      r_stop_pend <= 1'b0;
      r_tag       <= '0;
      r_valid     <= 1'b0;
      r_cnt       <= '0;
    end else begin
      r_valid <= w_done;
      if (w_enter) begin
        r_s    <= w_first;
        r_dcnt <= dwell;
      end else if (w_done) begin
        r_tag <= r_s;
        r_cnt <= r_cnt + CNT_W'(1);
        if (!w_halt) begin
          r_s    <= w_nxt;
          r_dcnt <= dwell;
        end
      end else if (r_state == ST_SCAN) begin
        r_dcnt <= r_dcnt - DWELL_W'(1);
        if (stop) r_stop_pend <= 1'b1;
      end else if (r_state == ST_DRAIN) begin
        r_stop_pend <= 1'b0;
      end
    end
  end

  always_comb begin
    s         = r_s;
    busy      = r_busy;
    smp_valid = r_valid;
    smp_ch    = r_tag;
    visit_cnt = r_cnt;
  end

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Bench for mux_scan_ctrl: directed scenarios plus random traffic,
// checked every cycle against a behavioural model of the scan rules.
module tb_mux_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       stop;
  logic [3:0] en_mask;
  logic [3:0] dwell;
  logic [1:0] s;
  logic       busy;
  logic       smp_valid;
  logic [1:0] smp_ch;
  logic [7:0] visit_cnt;

  mux_scan_ctrl #(.DWELL_W(4), .CNT_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .stop      (stop),
    .en_mask   (en_mask),
    .dwell     (dwell),
    .s         (s),
    .busy      (busy),
    .smp_valid (smp_valid),
    .smp_ch    (smp_ch),
    .visit_cnt (visit_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  // Model state: phase 0=idle 1=scanning 2=draining.
  int         m_phase = 0;
  int         m_s     = 0;
  int         m_left  = 0;
  bit         m_stop  = 1'b0;
  bit         m_vld   = 1'b0;
  int         m_ch    = 0;
  logic [7:0] m_cnt   = '0;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, want %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int lowest(input logic [3:0] m);
    for (int i = 0; i < 4; i++) if (m[i]) return i;
    return 0;
  endfunction

  function automatic int rr(input int cur, input logic [3:0] m);
    for (int k = 1; k <= 4; k++) begin
      if (m[(cur + k) % 4]) return (cur + k) % 4;
    end
    return cur;
  endfunction

  task automatic model_step();
    if (!rst_n) begin
      m_phase = 0; m_s = 0; m_left = 0; m_stop = 0;
      m_vld = 0; m_ch = 0; m_cnt = '0;
    end else begin
      m_vld = 0;
      if (m_phase == 0) begin
        if (start && !stop && en_mask != 0) begin
          m_phase = 1;
          m_s = lowest(en_mask);
          m_left = int'(dwell);
        end
      end else if (m_phase == 1) begin
        if (m_left == 0) begin
          m_vld = 1;
          m_ch = m_s;
          m_cnt = m_cnt + 8'd1;
          if (m_stop || stop || en_mask == 0) begin
            m_phase = 2;
          end else begin
            m_s = rr(m_s, en_mask);
            m_left = int'(dwell);
          end
        end else begin
          m_left--;
          if (stop) m_stop = 1;
        end
      end else begin
        m_phase = 0;
        m_stop = 0;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    start = 1'b0;
    stop  = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("s", int'(s), m_s);
      chk("busy", int'(busy), int'(m_phase != 0));
      chk("smp_valid", int'(smp_valid), int'(m_vld));
      chk("smp_ch", int'(smp_ch), m_ch);
      chk("visit_cnt", int'(visit_cnt), int'(m_cnt));
    end
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; stop = 1'b0;
    en_mask = '0; dwell = '0;
    tick();
    tick();
    chk_en = 1'b1;
    rst_n = 1'b1;
    chk("rst_s", int'(s), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_vld", int'(smp_valid), 0);
    chk("rst_cnt", int'(visit_cnt), 0);

    // All four channels, one cycle each.
    en_mask = 4'b1111; dwell = 4'd0; start = 1'b1;
    tick();
    chk("t1_s0", int'(s), 0);
    chk("t1_busy", int'(busy), 1);
    chk("t1_v0", int'(smp_valid), 0);
    tick();
    chk("t1_s1", int'(s), 1);
    chk("t1_v1", int'(smp_valid), 1);
    chk("t1_ch1", int'(smp_ch), 0);
    tick();
    chk("t1_s2", int'(s), 2);
    chk("t1_ch2", int'(smp_ch), 1);

    // Channels 1 and 3, three cycles each.
    do_reset();
    en_mask = 4'b1010; dwell = 4'd2; start = 1'b1;
    tick();
    chk("t2_s", int'(s), 1);
    tick(); tick();
    chk("t2_s_hold", int'(s), 1);
    chk("t2_nov", int'(smp_valid), 0);
    tick();
    chk("t2_s3", int'(s), 3);
    chk("t2_v", int'(smp_valid), 1);
    chk("t2_ch", int'(smp_ch), 1);

    // Graceful stop on channel 2.
    do_reset();
    en_mask = 4'b0100; dwell = 4'd3; start = 1'b1;
    tick();
    tick();
    stop = 1'b1;
    tick();
    tick();
    chk("t3_s", int'(s), 2);
    tick();
    chk("t3_drain_v", int'(smp_valid), 1);
    chk("t3_drain_ch", int'(smp_ch), 2);
    chk("t3_drain_busy", int'(busy), 1);
    tick();
    chk("t3_idle_busy", int'(busy), 0);

    // Ignored starts.
    do_reset();
    en_mask = 4'b0000; start = 1'b1;
    tick();
    chk("t4_busy0", int'(busy), 0);
    en_mask = 4'b1111; start = 1'b1; stop = 1'b1;
    tick();
    chk("t4_busy1", int'(busy), 0);
    chk("t4_s", int'(s), 0);

    // Live mask change while on channel 1.
    en_mask = 4'b1111; dwell = 4'd1; start = 1'b1;
    tick();
    tick(); tick();
    en_mask = 4'b0100;
    tick(); tick();
    chk("t5_s2", int'(s), 2);
    tick(); tick();
    chk("t5_s2b", int'(s), 2);
    en_mask = 4'b0000;
    tick(); tick(); tick();
    en_mask = 4'b1111;

    // Reset mid-dwell on channel 3.
    do_reset();
    en_mask = 4'b1000; dwell = 4'd5; start = 1'b1;
    tick(); tick(); tick();
    rst_n = 1'b0;
    tick();
    chk("t6_s", int'(s), 0);
    chk("t6_busy", int'(busy), 0);
    chk("t6_v", int'(smp_valid), 0);
    rst_n = 1'b1;
    tick();
    chk("t6_nov", int'(smp_valid), 0);

    // Visit counter wrap.
    en_mask = 4'b1111; dwell = 4'd0; start = 1'b1;
    tick();
    for (int i = 0; i < 255; i++) tick();
    chk("wrap_255", int'(visit_cnt), 255);
    tick();
    chk("wrap_0", int'(visit_cnt), 0);

    // Random traffic.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      rst_n = ($urandom_range(0, 299) != 0);
      start = ($urandom_range(0, 3) == 0);
      stop  = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 9) == 0) en_mask = 4'($urandom);
      if ($urandom_range(0, 7) == 0) dwell = 4'($urandom_range(0, 4));
      tick();
    end

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
